// File: rtl/seq_mult16_ctrl_pkg.sv
// Shared types and constants for the 16x16 sequential multiplier controller.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                STEP_W    = 2;
  localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;
  localparam int                ACC_W     = 32;
  localparam int                OP_W      = 16;
  localparam int                BYTE_W    = 8;

  // Partial product aligned for its step: LL no shift, HL/LH one byte, HH two bytes.
  function automatic logic [ACC_W-1:0] step_shift(input logic [OP_W-1:0]   p,
                                                  input logic [STEP_W-1:0] s);
    logic [ACC_W-1:0] w;
    w = {{(ACC_W-OP_W){1'b0}}, p};
    if (s == 2'd0)           return w;
    else if (s == LAST_STEP) return w << (2*BYTE_W);
    else                     return w << BYTE_W;
  endfunction

endpackage

// File: rtl/seq_mult16_ctrl.sv
// Sequencer for a 16x16 -> 32 product on an external 8x8 multiplier, four
// byte-pair steps (LL, HL, LH, HH), each lasting MUL_LAT+1 cycles.
// Optional build macro MULT_SEQ_SIGNED_EN adds op_signed: sign-magnitude
// operands are latched and the final accumulation is negated when needed.
//
// state | meaning
// IDLE  | ready for a command
// MUL   | driving byte operands, accumulating partial products
// DONE  | result presented, waiting for res_ready
module seq_mult16_ctrl
  import seq_mult_pkg::*;
#(
  parameter int MUL_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result,
  output logic              busy,
  output logic [BYTE_W-1:0] mul_a,
  output logic [BYTE_W-1:0] mul_b,
  input  logic [OP_W-1:0]   mul_p
`ifdef MULT_SEQ_SIGNED_EN
  ,
  input  logic              op_signed
`endif
);

  localparam logic [1:0] LAT_INIT = 2'(MUL_LAT);

  state_t              r_state;
  logic [OP_W-1:0]     r_op_a;
  logic [OP_W-1:0]     r_op_b;
  logic [ACC_W-1:0]    r_acc;
  logic [STEP_W-1:0]   r_step;
  logic [1:0]          r_wait;
  logic                r_start_ready;
  logic                r_res_valid;
  logic [ACC_W-1:0]    r_result;
  logic [BYTE_W-1:0]   r_mul_a;
  logic [BYTE_W-1:0]   r_mul_b;

  logic [OP_W-1:0]     w_in_a;
  logic [OP_W-1:0]     w_in_b;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [ACC_W-1:0]    w_res_nxt;

`ifdef MULT_SEQ_SIGNED_EN
  logic                r_neg;
  logic                w_in_neg;

  // Signed mode works on magnitudes; 0x8000 negates to itself, which is the right magnitude.
  always_comb begin
    w_in_a   = (op_signed && op_a[OP_W-1]) ? (~op_a + 1'b1) : op_a;
    w_in_b   = (op_signed && op_b[OP_W-1]) ? (~op_b + 1'b1) : op_b;
    w_in_neg = op_signed & (op_a[OP_W-1] ^ op_b[OP_W-1]);
  end
`else
  // Unsigned build latches operands as given.
  always_comb begin
    w_in_a = op_a;
    w_in_b = op_b;
  end
`endif

  // Next step index and accumulator value at the end of the current step.
  always_comb begin
    w_step_nxt = r_step + 1'b1;
    w_acc_nxt  = r_acc + step_shift(mul_p, r_step);
`ifdef MULT_SEQ_SIGNED_EN
    w_res_nxt  = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
`else
    w_res_nxt  = w_acc_nxt;
`endif
  end

  // Controller FSM with registered handshake and multiplier operand outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_acc         <= '0;
      r_step        <= '0;
      r_wait        <= '0;
      r_start_ready <= 1'b0;
      r_res_valid   <= 1'b0;
      r_result      <= '0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      r_neg         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_start_ready <= 1'b1;
          if (start_valid && r_start_ready) begin
            r_op_a        <= w_in_a;
            r_op_b        <= w_in_b;
            r_acc         <= '0;
            r_step        <= '0;
            r_wait        <= LAT_INIT;
            r_mul_a       <= w_in_a[BYTE_W-1:0];
            r_mul_b       <= w_in_b[BYTE_W-1:0];
            r_start_ready <= 1'b0;
            r_state       <= MUL;
`ifdef MULT_SEQ_SIGNED_EN
            r_neg         <= w_in_neg;
`endif
          end
        end
        MUL: begin
          if (r_wait != 2'd0) begin
            r_wait <= r_wait - 1'b1;
          end else begin
            r_acc <= w_acc_nxt;
            if (r_step == LAST_STEP) begin
              r_result    <= w_res_nxt;
              r_res_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_step  <= w_step_nxt;
              r_wait  <= LAT_INIT;
              r_mul_a <= w_step_nxt[0] ? r_op_a[OP_W-1:BYTE_W] : r_op_a[BYTE_W-1:0];
              r_mul_b <= w_step_nxt[1] ? r_op_b[OP_W-1:BYTE_W] : r_op_b[BYTE_W-1:0];
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign result      = r_result;
  assign busy        = (r_state != IDLE);
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;

endmodule

// File: tb/tb_seq_mult16_ctrl.sv
// Bench for seq_mult16_ctrl: two instances (MUL_LAT=0 and MUL_LAT=2), each
// with its own 8x8 multiplier model, driven from a vector table, a reset
// corner case and random operations checked against a plain a*b model.
module tb_seq_mult16_ctrl;

  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv  [2];
  logic        rr  [2];
  logic [15:0] oa  [2];
  logic [15:0] ob  [2];
  logic [15:0] mp  [2];
  logic        sr  [2];
  logic        rv  [2];
  logic        bz  [2];
  logic [31:0] res [2];
  logic [7:0]  ma  [2];
  logic [7:0]  mb  [2];
`ifdef MULT_SEQ_SIGNED_EN
  logic        sg  [2];
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? LAT0 : LAT1;

    seq_mult16_ctrl #(.MUL_LAT(L)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (sv[g]),
      .start_ready (sr[g]),
      .op_a        (oa[g]),
      .op_b        (ob[g]),
      .res_valid   (rv[g]),
      .res_ready   (rr[g]),
      .result      (res[g]),
      .busy        (bz[g]),
      .mul_a       (ma[g]),
      .mul_b       (mb[g]),
      .mul_p       (mp[g])
`ifdef MULT_SEQ_SIGNED_EN
      ,
      .op_signed   (sg[g])
`endif
    );

    if (L == 0) begin : g_comb
      assign mp[g] = {8'h00, ma[g]} * {8'h00, mb[g]};
    end else begin : g_pipe
      logic [15:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= {8'h00, ma[g]} * {8'h00, mb[g]};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign mp[g] = pipe[L-1];
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    int          stall;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    logic signed [31:0] sa, sb;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return 32'(sa * sb);
    end
    return {16'h0000, a} * {16'h0000, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One complete operation; start_valid stays high while busy to show it is ignored.
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int stall, input logic [31:0] exp);
    int lat;
    int c;
    lat = (d == 0) ? LAT0 : LAT1;
    @(negedge clk);
    chk("idle_ready", {31'b0, sr[d]}, 32'd1);
    sv[d] = 1'b1;
    oa[d] = a;
    ob[d] = b;
    rr[d] = 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
    sg[d] = s;
`endif
    @(negedge clk);
    oa[d] = ~a;
    ob[d] = a ^ b ^ 16'h5A5A;
    c = 0;
    if (!s) begin
      chk("mul_a_ll", {24'b0, ma[d]}, {24'b0, a[7:0]});
      chk("mul_b_ll", {24'b0, mb[d]}, {24'b0, b[7:0]});
    end
    while (!rv[d] && c < 64) begin
      chk("busy_not_ready", {30'b0, bz[d], sr[d]}, 32'd2);
      @(negedge clk);
      c++;
    end
    chk("latency", c, 4 * (lat + 1));
    chk("result", res[d], exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid_ready", {30'b0, rv[d], sr[d]}, 32'd2);
      chk("hold_result", res[d], exp);
    end
    if (!s) chk("mul_frozen_hh", {16'b0, ma[d], mb[d]}, {16'b0, a[15:8], b[15:8]});
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    chk("release", {29'b0, rv[d], sr[d], bz[d]}, 32'd2);
    sv[d] = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    int          rd;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sv[d] = 1'b0; rr[d] = 1'b0; oa[d] = '0; ob[d] = '0;
`ifdef MULT_SEQ_SIGNED_EN
      sg[d] = 1'b0;
`endif
    end

    tbl.push_back('{16'h1234, 16'h5678, 1'b0, 0,  32'h06260060});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 2,  32'hFFFE0001});
    tbl.push_back('{16'h0000, 16'hABCD, 1'b0, 0,  32'h00000000});
    tbl.push_back('{16'h00FF, 16'hFF00, 1'b0, 10, 32'h00FE0100});
    tbl.push_back('{16'h0003, 16'h0005, 1'b0, 1,  32'h0000000F});
`ifdef MULT_SEQ_SIGNED_EN
    tbl.push_back('{16'hFFFE, 16'h0003, 1'b1, 0,  32'hFFFFFFFA});
    tbl.push_back('{16'h8000, 16'h8000, 1'b1, 3,  32'h40000000});
    tbl.push_back('{16'hFFFE, 16'h0003, 1'b0, 0,  32'h0002FFFA});
`endif

    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, sr[d]}, 32'd0);
      chk("rst_valid_busy", {30'b0, rv[d], bz[d]}, 32'd0);
      chk("rst_result", res[d], 32'd0);
      chk("rst_mul", {16'b0, ma[d], mb[d]}, 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      foreach (tbl[i])
        run_op(d, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].stall, tbl[i].exp);

    // Reset during step 2 of an operation on the zero-latency instance.
    @(negedge clk);
    sv[0] = 1'b1; oa[0] = 16'h1234; ob[0] = 16'h5678;
    @(negedge clk);
    sv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'b0, bz[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_ready", {31'b0, sr[0]}, 32'd0);
    chk("midop_rst_valid_busy", {30'b0, rv[0], bz[0]}, 32'd0);
    chk("midop_rst_result", res[0], 32'd0);
    chk("midop_rst_mul", {16'b0, ma[0], mb[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_result", {31'b0, rv[0]}, 32'd0);
    run_op(0, 16'h0003, 16'h0005, 1'b0, 0, 32'h0000000F);

    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rd = k % 2;
`ifdef MULT_SEQ_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (k % 50 == 0) ra = 16'hFFFF;
      run_op(rd, ra, rb, rs, int'($urandom_range(0, 3)), ref_mul(ra, rb, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
